// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - operand FIFOs and sequencer feeding a pipelined MAC for one dot product
// Optional sticky error flag built only when MAC_FEEDER_ERR_EN is defined.

module mac_feeder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign drop    = wr_en && full;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mac_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_wr_en,
    input  logic [DATA_WIDTH-1:0]     a_wr_data,
    input  logic                      b_wr_en,
    input  logic [DATA_WIDTH-1:0]     b_wr_data,
    output logic                      a_full,
    output logic                      b_full,
    input  logic                      start,
    output logic                      busy,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic [DATA_WIDTH-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]     mac_b,
    input  logic [3*DATA_WIDTH-1:0]   mac_cout,
    output logic [3*DATA_WIDTH-1:0]   result,
    output logic                      result_valid,
    output logic                      err
);
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        SETTLE,
        CAPTURE
    } state_t;

    localparam logic [7:0] LAST_PAIR = 8'(VEC_LEN - 1);

    state_t                state;
    state_t                state_next;
    logic [7:0]            pair_cnt;
    logic                  pop;
    logic                  en_c;
    logic                  clr_c;
    logic [DATA_WIDTH-1:0] a_head;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  a_empty;
    logic                  b_empty;
    logic                  a_drop;
    logic                  b_drop;

    mac_feeder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (a_wr_en),
        .wr_data (a_wr_data),
        .rd_en   (pop),
        .rd_data (a_head),
        .full    (a_full),
        .empty   (a_empty),
        .drop    (a_drop)
    );

    mac_feeder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (b_wr_en),
        .wr_data (b_wr_data),
        .rd_en   (pop),
        .rd_data (b_head),
        .full    (b_full),
        .empty   (b_empty),
        .drop    (b_drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        en_c       = 1'b0;
        clr_c      = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr_c      = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                if (!a_empty && !b_empty) begin
                    pop  = 1'b1;
                    en_c = 1'b1;
                    if (pair_cnt == LAST_PAIR) begin
                        state_next = DRAIN;
                    end
                end
            end
            // Zero operands with en high push the MAC's last registered product into its sum.
            DRAIN: begin
                en_c       = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign mac_en  = en_c && !rst;
    assign mac_clr = clr_c && !rst;
    assign mac_a   = (pop && !rst) ? a_head : '0;
    assign mac_b   = (pop && !rst) ? b_head : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                pair_cnt <= '0;
            end else if (pop) begin
                pair_cnt <= pair_cnt + 1'b1;
            end
            result_valid <= (state == CAPTURE);
            if (state == CAPTURE) begin
                result <= mac_cout;
            end
        end
    end

`ifdef MAC_FEEDER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (a_drop || b_drop || (start && busy)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_drop;

    assign unused_drop = a_drop ^ b_drop;
    assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - scoreboard bench for mac_feeder with a behavioural pipelined MAC

module tb_mac_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int VL    = 4;
`ifdef MAC_FEEDER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            a_wr_en;
    logic [DW-1:0]   a_wr_data;
    logic            b_wr_en;
    logic [DW-1:0]   b_wr_data;
    logic            a_full;
    logic            b_full;
    logic            start;
    logic            busy;
    logic            mac_en;
    logic            mac_clr;
    logic [DW-1:0]   mac_a;
    logic [DW-1:0]   mac_b;
    logic [3*DW-1:0] mac_cout;
    logic [3*DW-1:0] result;
    logic            result_valid;
    logic            err;

    logic [2*DW-1:0] prod_q;
    logic [3*DW-1:0] acc_q;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int model_a[$];
    int model_b[$];

    always #5 clk = ~clk;

    mac_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .VEC_LEN(VL)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_wr_en      (a_wr_en),
        .a_wr_data    (a_wr_data),
        .b_wr_en      (b_wr_en),
        .b_wr_data    (b_wr_data),
        .a_full       (a_full),
        .b_full       (b_full),
        .start        (start),
        .busy         (busy),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_cout     (mac_cout),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    // Downstream MAC: registered product, accumulated one enable later.
    always @(posedge clk) begin
        if (mac_clr) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (mac_en) begin
            prod_q <= mac_a * mac_b;
            acc_q  <= acc_q + prod_q;
        end
    end
    assign mac_cout = acc_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit wa, input int va, input bit wb, input int vb);
        a_wr_en   = wa;
        a_wr_data = DW'(va);
        b_wr_en   = wb;
        b_wr_data = DW'(vb);
        if (wa && model_a.size() < DEPTH) model_a.push_back(va);
        if (wb && model_b.size() < DEPTH) model_b.push_back(vb);
        tick();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic commit();
        int sum = 0;
        for (int i = 0; i < VL; i++) sum += model_a.pop_front() * model_b.pop_front();
        exp_q.push_back(sum);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("done_in_time", result_valid, 1);
    endtask

    always @(negedge clk) begin
        check("en_clr_exclusive", mac_en & mac_clr, 0);
        if (!mac_en) check("ab_zero_when_idle", {mac_a, mac_b}, 0);
        if (result_valid) begin
            check("result_pending", exp_q.size(), 1);
            if (exp_q.size() != 0) check("result", result, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;
        rst = 1'b1; start = 1'b0;
        a_wr_en = 1'b0; a_wr_data = '0; b_wr_en = 1'b0; b_wr_data = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_a_full", a_full, 0);
        check("rst_b_full", b_full, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Basic dot product and latency
        for (int i = 0; i < 4; i++) push(1, i + 1, 1, i + 5);
        commit();
        pulse_start();
        wait_done(cyc);
        check("latency", cyc, VL + 4);
        tick();
        check("valid_one_cycle", result_valid, 0);

        // Leftover entries and pointer wrap
        for (int i = 0; i < 6; i++) push(1, i + 2, 1, i / 2 + 1);
        commit();
        pulse_start();
        wait_done(cyc);
        push(1, 9, 1, 2);
        push(1, 9, 1, 2);
        commit();
        pulse_start();
        wait_done(cyc);
        check("latency_wrap", cyc, VL + 4);
        tick();

        // Stall on empty B
        push(1, 1, 1, 5);
        push(1, 2, 1, 6);
        push(1, 3, 0, 0);
        push(1, 4, 0, 0);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (mac_en) seen++;
            tick();
        end
        check("stall_pairs", seen, 2);
        check("stall_en_low", mac_en, 0);
        check("stall_busy", busy, 1);
        push(0, 0, 1, 7);
        push(0, 0, 1, 8);
        commit();
        wait_done(cyc);
        tick();

        // Overfill A; the ninth value (18) must be dropped
        for (int i = 0; i < 9; i++) begin
            push(1, i + 10, 0, 0);
            if (i == 6) check("a_full_at_7", a_full, 0);
            if (i == 7) check("a_full_at_8", a_full, 1);
        end
        check("a_full_held", a_full, 1);
        check("err_on_drop", err, ERR_EXP);
        for (int i = 0; i < 8; i++) push(0, 0, 1, i + 1);
        check("b_full", b_full, 1);
        commit();
        pulse_start();
        wait_done(cyc);
        tick();
        check("a_full_after_run", a_full, 0);
        commit();
        pulse_start();
        wait_done(cyc);
        tick();
        for (int i = 0; i < 4; i++) push(1, 2, 1, 3);
        commit();
        pulse_start();
        wait_done(cyc);
        tick();

        // Reset mid-stream after two pairs
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) push(1, i + 1, 1, i + 5);
        pulse_start();
        seen = 0;
        cyc = 0;
        while (seen < 2 && cyc < 50) begin
            if (mac_en) seen++;
            tick();
            cyc++;
        end
        check("two_pairs_seen", seen, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_a_full", a_full, 0);
        check("abort_b_full", b_full, 0);
        check("abort_result", result, 0);
        check("abort_err", err, 0);
        model_a.delete();
        model_b.delete();
        push(1, 3, 1, 5);
        push(1, 1, 1, 9);
        push(1, 4, 1, 2);
        push(1, 1, 1, 6);
        commit();
        pulse_start();
        wait_done(cyc);
        check("latency_after_abort", cyc, VL + 4);
        tick();

        // Max operands, and start while busy is ignored
        for (int i = 0; i < 4; i++) push(1, 255, 1, 255);
        commit();
        pulse_start();
        tick(); tick();
        pulse_start();
        wait_done(cyc);
        tick();
        check("err_start_busy", err, ERR_EXP);
        for (int i = 0; i < 20; i++) tick();
        check("idle_after_ignore", busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
